// File: rtl/multicycle_seq.sv
// rtl/multicycle_seq.sv - multi-cycle fetch/decode/execute control sequencer for addi/bne
//
// Purpose:
//   Steps one instruction at a time through FETCH, DECODE, EXEC and WB or BR.
//   It fetches over a req/ack instruction-memory handshake and decodes addi and bne.
//   It drives the ALU, immediate, register-file and PC strobes for each phase.
//   It counts retired instructions. It traps on an illegal opcode or a fetch timeout.
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst         in   1      synchronous active-high reset; forces every output to 0
//   imem_req    out  1      fetch request, held until imem_ack
//   imem_ack    in   1      fetch complete, instr valid this cycle
//   instr       in   32     instruction word, sampled on imem_req & imem_ack
//   EQ          in   1      ALU equal flag, sampled when EXEC completes
//   stall       in   1      freezes DECODE/EXEC/WB/BR and blocks their write strobes
//   IRWrite     out  1      latch instr into IR
//   RegWrite    out  1      register-file write enable
//   PCWrite     out  1      PC update enable
//   PCsrc       out  1      0: PC+4, 1: PC+imm
//   ALUsrc      out  1      0: rs2, 1: immediate
//   ALUctrl     out  3      000 add, 001 subtract/compare
//   ImmSrc      out  2      00 I-type, 10 B-type
//   trap        out  1      sequencer halted; only rst leaves this state
//   trap_cause  out  2      00 none, 01 illegal instruction, 10 fetch timeout
//   retired     out  CNT_W  completed-instruction count, wraps silently

module multicycle_seq #(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [31:0]      instr,
  input  logic             EQ,
  input  logic             stall,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             PCWrite,
  output logic             PCsrc,
  output logic             ALUsrc,
  output logic [2:0]       ALUctrl,
  output logic [1:0]       ImmSrc,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_BR     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_ADDI   = 3'b000;
  localparam logic [2:0] F3_BNE    = 3'b001;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // The last wait count still allowed before the fetch is abandoned.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t             state;
  state_t             state_nx;
  logic [6:0]         ir_op;
  logic [2:0]         ir_f3;
  logic               eq_q;
  logic [7:0]         wait_cnt;
  logic [1:0]         cause_q;
  logic [1:0]         cause_nx;
  logic [CNT_W-1:0]   retired_q;
  logic               retire;
  logic               is_addi;
  logic               is_bne;
  logic               fetch_done;
  logic               fetch_timeout;

  // The decode result comes from the held IR fields.
  // It stays stable across every phase after FETCH.
  assign is_addi = (ir_op == OP_IMM)    && (ir_f3 == F3_ADDI);
  assign is_bne  = (ir_op == OP_BRANCH) && (ir_f3 == F3_BNE);

  assign fetch_done    = (state == S_FETCH) && imem_ack;
  assign fetch_timeout = (state == S_FETCH) && !imem_ack && (wait_cnt == WAIT_LAST);

  // Next-state logic.
  // Every non-FETCH phase holds while stall is high, so it runs exactly once after release.
  always_comb begin
    state_nx = state;
    cause_nx = cause_q;
    retire   = 1'b0;
    case (state)
      S_FETCH: begin
        if (imem_ack) begin
          state_nx = S_DECODE;
        end else if (fetch_timeout) begin
          state_nx = S_TRAP;
          cause_nx = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (!stall) begin
          if (is_addi || is_bne) begin
            state_nx = S_EXEC;
          end else begin
            state_nx = S_TRAP;
            cause_nx = CAUSE_ILLEGAL;
          end
        end
      end
      S_EXEC: begin
        if (!stall) begin
          state_nx = is_addi ? S_WB : S_BR;
        end
      end
      S_WB, S_BR: begin
        if (!stall) begin
          state_nx = S_FETCH;
          retire   = 1'b1;
        end
      end
      S_TRAP: begin
        state_nx = S_TRAP;
      end
      default: begin
        state_nx = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      cause_q   <= 2'b00;
      retired_q <= '0;
      wait_cnt  <= 8'd0;
      eq_q      <= 1'b0;
      ir_op     <= 7'd0;
      ir_f3     <= 3'd0;
    end else begin
      state   <= state_nx;
      cause_q <= cause_nx;
      if (fetch_done) begin
        ir_op    <= instr[6:0];
        ir_f3    <= instr[14:12];
        wait_cnt <= 8'd0;
      end else if (state == S_FETCH) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      // The BR phase uses the flag value from the EXEC cycle that actually completed.
      if ((state == S_EXEC) && !stall) begin
        eq_q <= EQ;
      end
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  // Output decode.
  // All outputs are gated off by rst so nothing fires in the reset cycle.
  always_comb begin
    imem_req = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    PCWrite  = 1'b0;
    PCsrc    = 1'b0;
    ALUsrc   = 1'b0;
    ALUctrl  = 3'b000;
    ImmSrc   = 2'b00;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          IRWrite  = imem_ack;
        end
        S_EXEC, S_WB, S_BR: begin
          // The ALU and immediate selects stay driven through stalls.
          // The datapath result therefore stays stable.
          if (is_bne) begin
            ALUsrc  = 1'b0;
            ALUctrl = 3'b001;
            ImmSrc  = 2'b10;
          end else if (is_addi) begin
            ALUsrc  = 1'b1;
            ALUctrl = 3'b000;
            ImmSrc  = 2'b00;
          end
          if (state == S_WB) begin
            RegWrite = !stall;
            PCWrite  = !stall;
          end
          if (state == S_BR) begin
            PCWrite = !stall;
            PCsrc   = !eq_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign trap       = !rst && (state == S_TRAP);
  assign trap_cause = rst ? 2'b00 : cause_q;
  assign retired    = rst ? '0 : retired_q;

endmodule

// File: tb/tb_multicycle_seq.sv
// tb/tb_multicycle_seq.sv - self-checking bench for multicycle_seq

module tb_multicycle_seq;

  localparam int MW = 15;
  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] BNE  = 32'h00209463;
  localparam logic [31:0] ILL  = 32'h00000033;

  localparam int P_FETCH  = 0;
  localparam int P_DECODE = 1;
  localparam int P_EXEC   = 2;
  localparam int P_WB     = 3;
  localparam int P_BR     = 4;
  localparam int P_TRAP   = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_ack = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        EQ = 1'b0;
  logic        stall = 1'b0;

  logic        imem_req, IRWrite, RegWrite, PCWrite, PCsrc, ALUsrc, trap;
  logic [2:0]  ALUctrl;
  logic [1:0]  ImmSrc, trap_cause;
  logic [31:0] retired;

  logic        imem_req_4, IRWrite_4, RegWrite_4, PCWrite_4, PCsrc_4, ALUsrc_4, trap_4;
  logic [2:0]  ALUctrl_4;
  logic [1:0]  ImmSrc_4, trap_cause_4;
  logic [3:0]  retired_4;

  multicycle_seq #(.CNT_W(32), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ack(imem_ack), .instr(instr),
    .EQ(EQ), .stall(stall), .IRWrite(IRWrite), .RegWrite(RegWrite), .PCWrite(PCWrite),
    .PCsrc(PCsrc), .ALUsrc(ALUsrc), .ALUctrl(ALUctrl), .ImmSrc(ImmSrc), .trap(trap),
    .trap_cause(trap_cause), .retired(retired)
  );

  multicycle_seq #(.CNT_W(4), .MAX_WAIT(MW)) dut4 (
    .clk(clk), .rst(rst), .imem_req(imem_req_4), .imem_ack(imem_ack), .instr(instr),
    .EQ(EQ), .stall(stall), .IRWrite(IRWrite_4), .RegWrite(RegWrite_4), .PCWrite(PCWrite_4),
    .PCsrc(PCsrc_4), .ALUsrc(ALUsrc_4), .ALUctrl(ALUctrl_4), .ImmSrc(ImmSrc_4), .trap(trap_4),
    .trap_cause(trap_cause_4), .retired(retired_4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: instruction-level view of the sequencer.
  int          m_ph = P_FETCH;
  int          m_wait = 0;
  logic [1:0]  m_cause = 2'b00;
  int unsigned m_ret = 0;
  logic [31:0] m_ir = 32'd0;
  logic        m_eqq = 1'b0;

  // Values captured just before each active edge.
  logic [13:0] a_vec, a_vec4, e_vec, e_mask;
  int unsigned a_ret, e_ret;
  logic [3:0]  a_ret4;

  // Vector bit order: req irw rw pcw pcs alusrc ctrl[2:0] imm[1:0] trap cause[1:0]
  function automatic logic [13:0] ov(input logic req, irw, rw, pcw, pcs, asrc,
                                     input logic [2:0] ctrl, input logic [1:0] imm,
                                     input logic trp, input logic [1:0] cause);
    return {req, irw, rw, pcw, pcs, asrc, ctrl, imm, trp, cause};
  endfunction

  localparam logic [13:0] ALU_MASK = 14'b11_1111_0000_0111;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_outputs(input logic r, input logic a, input logic s);
    logic addi, bne;
    logic req, irw, rw, pcw, pcs, asrc, trp;
    logic [2:0] ctrl;
    logic [1:0] imm;
    addi = (m_ir[6:0] == 7'h13) && (m_ir[14:12] == 3'd0);
    bne  = (m_ir[6:0] == 7'h63) && (m_ir[14:12] == 3'd1);
    {req, irw, rw, pcw, pcs, asrc, trp} = '0;
    ctrl = 3'd0;
    imm = 2'd0;
    e_mask = '1;
    if (r) begin
      e_vec = '0;
      e_ret = 0;
    end else begin
      req = (m_ph == P_FETCH);
      irw = req && a;
      trp = (m_ph == P_TRAP);
      if (m_ph == P_EXEC || m_ph == P_WB) begin
        if (addi) begin
          asrc = 1'b1;
        end else if (bne) begin
          ctrl = 3'd1;
          imm = 2'd2;
        end
      end
      if (m_ph == P_WB) begin
        rw = !s;
        pcw = !s;
      end
      if (m_ph == P_BR) begin
        pcw = !s;
        pcs = !m_eqq;
        e_mask = ALU_MASK;
      end
      e_vec = ov(req, irw, rw, pcw, pcs, asrc, ctrl, imm, trp, m_cause);
      e_ret = m_ret;
    end
  endtask

  task automatic model_update(input logic r, input logic a, input logic [31:0] ins,
                              input logic e, input logic s);
    logic addi, bne;
    addi = (m_ir[6:0] == 7'h13) && (m_ir[14:12] == 3'd0);
    bne  = (m_ir[6:0] == 7'h63) && (m_ir[14:12] == 3'd1);
    if (r) begin
      m_ph = P_FETCH;
      m_wait = 0;
      m_cause = 2'b00;
      m_ret = 0;
    end else if (m_ph == P_FETCH) begin
      if (a) begin
        m_ir = ins;
        m_wait = 0;
        m_ph = P_DECODE;
      end else begin
        m_wait++;
        if (m_wait >= MW) begin
          m_ph = P_TRAP;
          m_cause = 2'b10;
        end
      end
    end else if (m_ph != P_TRAP && !s) begin
      if (m_ph == P_DECODE) begin
        if (addi || bne) begin
          m_ph = P_EXEC;
        end else begin
          m_ph = P_TRAP;
          m_cause = 2'b01;
        end
      end else if (m_ph == P_EXEC) begin
        m_eqq = e;
        m_ph = addi ? P_WB : P_BR;
      end else begin
        m_ret = m_ret + 1;
        m_ph = P_FETCH;
      end
    end
  endtask

  // One clock cycle. Drive after the falling edge, sample 1 time unit later,
  // then advance the model at the rising edge.
  task automatic step(input logic r, input logic a, input logic [31:0] ins,
                      input logic e, input logic s);
    @(negedge clk);
    rst = r;
    imem_ack = a;
    instr = ins;
    EQ = e;
    stall = s;
    #1;
    a_vec  = {imem_req, IRWrite, RegWrite, PCWrite, PCsrc, ALUsrc, ALUctrl, ImmSrc, trap, trap_cause};
    a_vec4 = {imem_req_4, IRWrite_4, RegWrite_4, PCWrite_4, PCsrc_4, ALUsrc_4, ALUctrl_4, ImmSrc_4,
              trap_4, trap_cause_4};
    a_ret  = retired;
    a_ret4 = retired_4;
    model_outputs(r, a, s);
    @(posedge clk);
    model_update(r, a, ins, e, s);
  endtask

  typedef struct {
    logic        r;
    logic        a;
    logic [31:0] ins;
    logic        e;
    logic        s;
    logic [13:0] ev;
    logic        ma;
    int unsigned er;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, a, input logic [31:0] ins, input logic e,
                              input logic [13:0] ev, input logic ma, input int unsigned er);
    vec_t v;
    v.r = r;
    v.a = a;
    v.ins = ins;
    v.e = e;
    v.s = 1'b0;
    v.ev = ev;
    v.ma = ma;
    v.er = er;
    return v;
  endfunction

  initial begin
    int irw_cnt;
    int req_cnt;
    logic [31:0] ins;
    logic r, a, e, s;

    tbl.push_back(mk(1, 1, ADDI, 0, ov(0,0,0,0,0,0,3'd0,2'd0,0,2'd0), 0, 0));
    tbl.push_back(mk(0, 1, ADDI, 0, ov(1,1,0,0,0,0,3'd0,2'd0,0,2'd0), 0, 0));
    tbl.push_back(mk(0, 0, ADDI, 0, ov(0,0,0,0,0,0,3'd0,2'd0,0,2'd0), 0, 0));
    tbl.push_back(mk(0, 0, ADDI, 0, ov(0,0,0,0,0,1,3'd0,2'd0,0,2'd0), 0, 0));
    tbl.push_back(mk(0, 1, ADDI, 0, ov(0,0,1,1,0,1,3'd0,2'd0,0,2'd0), 0, 0));
    tbl.push_back(mk(0, 1, BNE,  0, ov(1,1,0,0,0,0,3'd0,2'd0,0,2'd0), 0, 1));
    tbl.push_back(mk(0, 1, BNE,  0, ov(0,0,0,0,0,0,3'd0,2'd0,0,2'd0), 0, 1));
    tbl.push_back(mk(0, 1, BNE,  0, ov(0,0,0,0,0,0,3'd1,2'd2,0,2'd0), 0, 1));
    tbl.push_back(mk(0, 1, BNE,  1, ov(0,0,0,1,1,0,3'd0,2'd0,0,2'd0), 1, 1));
    tbl.push_back(mk(0, 1, BNE,  1, ov(1,1,0,0,0,0,3'd0,2'd0,0,2'd0), 0, 2));
    tbl.push_back(mk(0, 0, BNE,  1, ov(0,0,0,0,0,0,3'd0,2'd0,0,2'd0), 0, 2));
    tbl.push_back(mk(0, 0, BNE,  1, ov(0,0,0,0,0,0,3'd1,2'd2,0,2'd0), 0, 2));
    tbl.push_back(mk(0, 0, BNE,  0, ov(0,0,0,1,0,0,3'd0,2'd0,0,2'd0), 1, 2));
    tbl.push_back(mk(0, 1, ILL,  0, ov(1,1,0,0,0,0,3'd0,2'd0,0,2'd0), 0, 3));
    tbl.push_back(mk(0, 1, ILL,  0, ov(0,0,0,0,0,0,3'd0,2'd0,0,2'd0), 0, 3));
    tbl.push_back(mk(0, 0, ILL,  0, ov(0,0,0,0,0,0,3'd0,2'd0,1,2'd1), 0, 3));
    tbl.push_back(mk(0, 1, ADDI, 0, ov(0,0,0,0,0,0,3'd0,2'd0,1,2'd1), 0, 3));
    tbl.push_back(mk(1, 1, ADDI, 0, ov(0,0,0,0,0,0,3'd0,2'd0,0,2'd0), 0, 0));
    tbl.push_back(mk(0, 0, ADDI, 0, ov(1,0,0,0,0,0,3'd0,2'd0,0,2'd0), 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].a, tbl[i].ins, tbl[i].e, tbl[i].s);
      if (tbl[i].ma) begin
        chk($sformatf("table_row%0d_out", i), a_vec & ALU_MASK, tbl[i].ev & ALU_MASK);
      end else begin
        chk($sformatf("table_row%0d_out", i), a_vec, tbl[i].ev);
      end
      chk($sformatf("table_row%0d_retired", i), a_ret, tbl[i].er);
    end

    // Ack delayed by 3 cycles: the request spans 4 cycles with a single IR write.
    step(1, 0, ADDI, 0, 0);
    irw_cnt = 0;
    req_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, (i == 3), ADDI, 0, 0);
      irw_cnt += int'(a_vec[12]);
      req_cnt += int'(a_vec[13]);
    end
    chk("delayed_ack_req_cycles", req_cnt, 4);
    chk("delayed_ack_irwrite_pulses", irw_cnt, 1);

    // Fetch timeout: 15 unacknowledged cycles, then the sequencer halts.
    step(1, 0, ADDI, 0, 0);
    req_cnt = 0;
    for (int i = 0; i < MW; i++) begin
      step(0, 0, ADDI, 0, 0);
      req_cnt += int'(a_vec[13] && !a_vec[2]);
    end
    chk("timeout_req_cycles", req_cnt, MW);
    step(0, 0, ADDI, 0, 0);
    chk("timeout_trap", {a_vec[13], a_vec[2], a_vec[1:0]}, 4'b0_1_10);
    step(0, 1, ADDI, 0, 0);
    chk("timeout_trap_ignores_ack", {a_vec[13], a_vec[12], a_vec[2], a_vec[1:0]}, 5'b0_0_1_10);

    // Stall for 5 cycles in WB, then release.
    step(1, 0, ADDI, 0, 0);
    step(0, 1, ADDI, 0, 0);
    step(0, 0, ADDI, 0, 0);
    step(0, 0, ADDI, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, ADDI, 0, 1);
      chk($sformatf("stall_wb_%0d", i), {a_vec[13:10], a_vec[8], a_ret[3:0]}, {4'b0000, 1'b1, 4'd0});
    end
    step(0, 1, ADDI, 0, 0);
    chk("stall_release_wb", a_vec[11:10], 2'b11);
    step(0, 0, ADDI, 0, 0);
    chk("stall_release_retired", {a_vec[13], a_vec[11], a_ret}, {1'b1, 1'b0, 32'd1});

    // 17 back-to-back addi: the 4-bit counter wraps 15 -> 0 -> 1.
    step(1, 0, ADDI, 0, 0);
    for (int i = 0; i < 17; i++) begin
      step(0, 1, ADDI, 0, 0);
      chk($sformatf("wrap_count_%0d", i), {a_ret4, a_ret}, {4'(i % 16), 32'(i)});
      step(0, 1, ADDI, 0, 0);
      step(0, 1, ADDI, 0, 0);
      step(0, 1, ADDI, 0, 0);
    end
    step(0, 1, ADDI, 0, 0);
    chk("wrap_count_17", {a_ret4, a_ret}, {4'd1, 32'd17});
    step(0, 1, ADDI, 0, 0);
    step(1, 1, ADDI, 0, 0);
    chk("reset_in_exec_outputs", {a_vec, a_vec4, a_ret, a_ret4}, '0);
    step(0, 0, ADDI, 0, 0);
    chk("after_reset_fetch", {a_vec[13], a_vec[11:10], a_ret4, a_ret}, {1'b1, 2'b00, 4'd0, 32'd0});

    // Randomized traffic against the reference model.
    step(1, 0, ADDI, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 49) == 0);
      a = ($urandom_range(0, 9) < 6);
      e = $urandom_range(0, 1) == 1;
      s = ($urandom_range(0, 3) == 0);
      ins = $urandom;
      case ($urandom_range(0, 7))
        0, 1, 2, 3: ins = {ins[31:15], 3'b000, ins[11:7], 7'h13};
        4, 5, 6:    ins = {ins[31:15], 3'b001, ins[11:7], 7'h63};
        default:    ins = ins;
      endcase
      step(r, a, ins, e, s);
      chk($sformatf("rand_out_%0d", n), a_vec & e_mask, e_vec & e_mask);
      chk($sformatf("rand_retired_%0d", n), {a_ret, a_ret4, a_vec4 & e_mask},
          {e_ret, e_ret[3:0], e_vec & e_mask});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
